// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the memory command sequencer and the hexDisplay stage.
// ERROR is all-zero so the display falls back to its default pattern.
package mem_ctrl_pkg;

  localparam int STATE_W = 12;
  localparam int DATA_W  = 16;

  localparam logic [11:0] ST_IDLE       = 12'h001;
  localparam logic [11:0] ST_READ_ST0   = 12'h002;
  localparam logic [11:0] ST_READ_ST1   = 12'h004;
  localparam logic [11:0] ST_READ_ST2   = 12'h008;
  localparam logic [11:0] ST_READ_WAIT  = 12'h010;
  localparam logic [11:0] ST_READ_DONE  = 12'h020;
  localparam logic [11:0] ST_WRITE_ST0  = 12'h040;
  localparam logic [11:0] ST_WRITE_ST1  = 12'h080;
  localparam logic [11:0] ST_WRITE_ST2  = 12'h100;
  localparam logic [11:0] ST_WRITE_ST3  = 12'h200;
  localparam logic [11:0] ST_WRITE_ST4  = 12'h400;
  localparam logic [11:0] ST_WRITE_WAIT = 12'h800;
  localparam logic [11:0] ST_ERROR      = 12'h000;

  function automatic logic is_wait(input logic [11:0] s);
    return (s == ST_READ_WAIT) || (s == ST_WRITE_WAIT);
  endfunction

  function automatic logic is_busy(input logic [11:0] s);
    return !((s == ST_IDLE) || (s == ST_READ_DONE) || (s == ST_ERROR));
  endfunction

  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/mem_ctrl_fsm_step_timer.sv
// Loadable down-counter; done is high on the last cycle of the loaded interval.
module step_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign done = (cnt <= CNT_W'(1));

endmodule

// File: rtl/mem_ctrl_fsm.sv
// One-hot command sequencer driving a req/ack memory port; state and read
// data feed the hexDisplay stage directly.
module mem_ctrl_fsm
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W         = 8,
  parameter int STEP_CYCLES    = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_go,
  input  logic              wr_go,
  input  logic              clr,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [15:0]       wdata_in,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              mem_req,
  output logic              mem_we,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  output logic [11:0]       state,
  output logic [15:0]       rd_data,
  output logic              busy,
  output logic              err
);

  localparam int CNT_W = cnt_width(STEP_CYCLES, TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] STEP_V    = CNT_W'(STEP_CYCLES);
  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT_CYCLES);

  logic [11:0]       next_state;
  logic [ADDR_W-1:0] addr_lat;
  logic [15:0]       wdata_lat;
  logic              tmr_done;
  logic              tmr_load;
  logic [CNT_W-1:0]  tmr_val;

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (rd_go)      next_state = ST_READ_ST0;
        else if (wr_go) next_state = ST_WRITE_ST0;
      end
      ST_READ_DONE: begin
        if (rd_go)      next_state = ST_READ_ST0;
        else if (wr_go) next_state = ST_WRITE_ST0;
        else if (clr)   next_state = ST_IDLE;
      end
      ST_READ_ST0:   if (tmr_done) next_state = ST_READ_ST1;
      ST_READ_ST1:   if (tmr_done) next_state = ST_READ_ST2;
      ST_READ_ST2:   if (tmr_done) next_state = ST_READ_WAIT;
      ST_READ_WAIT: begin
        if (mem_ack)       next_state = ST_READ_DONE;
        else if (tmr_done) next_state = ST_ERROR;
      end
      ST_WRITE_ST0:  if (tmr_done) next_state = ST_WRITE_ST1;
      ST_WRITE_ST1:  if (tmr_done) next_state = ST_WRITE_ST2;
      ST_WRITE_ST2:  if (tmr_done) next_state = ST_WRITE_ST3;
      ST_WRITE_ST3:  if (tmr_done) next_state = ST_WRITE_ST4;
      ST_WRITE_ST4:  if (tmr_done) next_state = ST_WRITE_WAIT;
      ST_WRITE_WAIT: begin
        if (mem_ack)       next_state = ST_IDLE;
        else if (tmr_done) next_state = ST_ERROR;
      end
      ST_ERROR:      if (clr) next_state = ST_IDLE;
      default:       next_state = ST_IDLE;
    endcase
  end

  // One timer serves both the ST dwell and the WAIT timeout; it reloads on
  // every state change so it always counts cycles spent in the current state.
  always_comb begin
    tmr_load = (next_state != state);
    tmr_val  = is_wait(next_state) ? TIMEOUT_V : STEP_V;
  end

  step_timer #(
    .CNT_W(CNT_W)
  ) u_step_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Outputs are registered from next_state so they line up with state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      rd_data   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state   <= next_state;
      mem_req <= is_wait(next_state);
      mem_we  <= (next_state == ST_WRITE_ST4) || (next_state == ST_WRITE_WAIT);
      busy    <= is_busy(next_state);
      err     <= (next_state == ST_ERROR);
      if ((state == ST_READ_WAIT) && mem_ack) rd_data <= mem_rdata;
      if ((state == ST_READ_ST1) || (state == ST_WRITE_ST2)) mem_addr <= addr_lat;
      if (state == ST_WRITE_ST2) mem_wdata <= wdata_lat;
    end
  end

  always_ff @(posedge clk) begin
    if ((state == ST_READ_ST0) || (state == ST_WRITE_ST0)) addr_lat <= addr_in;
    if (state == ST_WRITE_ST1) wdata_lat <= wdata_in;
  end

endmodule

// File: tb/tb_mem_ctrl_fsm.sv
// Directed bench for mem_ctrl_fsm with a read/write scoreboard.
module tb_mem_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_go, wr_go, clr, mem_ack;
  logic [7:0]  addr_in;
  logic [15:0] wdata_in, mem_rdata;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata, rd_data;
  logic        mem_req, mem_we, busy, err;
  logic [11:0] state;

  logic        rd_go3, wr_go3, clr3, mem_ack3;
  logic [7:0]  addr_in3;
  logic [15:0] wdata_in3, mem_rdata3;
  logic [7:0]  mem_addr3;
  logic [15:0] mem_wdata3, rd_data3;
  logic        mem_req3, mem_we3, busy3, err3;
  logic [11:0] state3;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0]  a;
    logic [15:0] d;
  } wr_t;
  wr_t         wr_q[$];
  logic [15:0] rd_q[$];

  always #5 clk = ~clk;

  mem_ctrl_fsm #(.ADDR_W(8), .STEP_CYCLES(1), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .rd_go(rd_go), .wr_go(wr_go), .clr(clr),
    .addr_in(addr_in), .wdata_in(wdata_in), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .state(state),
    .rd_data(rd_data), .busy(busy), .err(err)
  );

  mem_ctrl_fsm #(.ADDR_W(8), .STEP_CYCLES(3), .TIMEOUT_CYCLES(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .rd_go(rd_go3), .wr_go(wr_go3), .clr(clr3),
    .addr_in(addr_in3), .wdata_in(wdata_in3), .mem_addr(mem_addr3),
    .mem_wdata(mem_wdata3), .mem_req(mem_req3), .mem_we(mem_we3),
    .mem_ack(mem_ack3), .mem_rdata(mem_rdata3), .state(state3),
    .rd_data(rd_data3), .busy(busy3), .err(err3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_read(input string tag);
    logic [15:0] e;
    if (rd_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s: observed read completion expected none queued", tag);
    end else begin
      e = rd_q.pop_front();
      chk(tag, 32'(rd_data), 32'(e));
    end
  endtask

  task automatic sb_write(input string tag);
    wr_t e;
    if (wr_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s: observed write request expected none queued", tag);
    end else begin
      e = wr_q.pop_front();
      chk({tag, "_addr"}, 32'(mem_addr), 32'(e.a));
      chk({tag, "_wdata"}, 32'(mem_wdata), 32'(e.d));
    end
  endtask

  initial begin
    logic [11:0] wseq [6];
    logic [11:0] exp3;
    wseq = '{12'h040, 12'h080, 12'h100, 12'h200, 12'h400, 12'h800};
    rst_n = 1'b0;
    rd_go = 0; wr_go = 0; clr = 0; mem_ack = 0;
    addr_in = 0; wdata_in = 0; mem_rdata = 0;
    rd_go3 = 0; wr_go3 = 0; clr3 = 0; mem_ack3 = 0;
    addr_in3 = 0; wdata_in3 = 0; mem_rdata3 = 0;
    repeat (3) tick();
    chk("rst_state", 32'(state), 32'h001);
    chk("rst_rd_data", 32'(rd_data), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    rst_n = 1'b1;
    tick();

    // Basic read: ack in the third WAIT cycle.
    addr_in = 8'h5A; rd_go = 1; rd_q.push_back(16'hBEEF);
    tick(); rd_go = 0;
    chk("rd_c1_state", 32'(state), 32'h002);
    chk("rd_c1_busy", 32'(busy), 32'h1);
    tick(); chk("rd_c2_state", 32'(state), 32'h004);
    tick(); chk("rd_c3_state", 32'(state), 32'h008);
    tick();
    chk("rd_c4_state", 32'(state), 32'h010);
    chk("rd_c4_req", 32'(mem_req), 32'h1);
    chk("rd_c4_we", 32'(mem_we), 32'h0);
    chk("rd_c4_addr", 32'(mem_addr), 32'h5A);
    tick(); tick();
    mem_ack = 1; mem_rdata = 16'hBEEF;
    tick(); mem_ack = 0; mem_rdata = 16'h0;
    chk("rd_c7_state", 32'(state), 32'h020);
    sb_read("rd_c7_data");
    chk("rd_c7_req", 32'(mem_req), 32'h0);
    chk("rd_c7_busy", 32'(busy), 32'h0);

    // Write launched straight from READ_DONE.
    addr_in = 8'h3C; wdata_in = 16'h1234; wr_go = 1;
    wr_q.push_back('{a: 8'h3C, d: 16'h1234});
    tick(); wr_go = 0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("wr_seq%0d", i), 32'(state), 32'(wseq[i]));
      if (i < 5) tick();
    end
    chk("wr_wait_req", 32'(mem_req), 32'h1);
    chk("wr_wait_we", 32'(mem_we), 32'h1);
    sb_write("wr_wait");
    chk("wr_rd_data_hold", 32'(rd_data), 32'hBEEF);
    mem_ack = 1;
    tick(); mem_ack = 0;
    chk("wr_done_state", 32'(state), 32'h001);
    chk("wr_done_busy", 32'(busy), 32'h0);
    chk("wr_done_req", 32'(mem_req), 32'h0);
    chk("wr_done_we", 32'(mem_we), 32'h0);

    // Simultaneous commands, ignored wr_go and early ack.
    addr_in = 8'h11; rd_go = 1; wr_go = 1;
    tick(); rd_go = 0; wr_go = 0;
    chk("both_go_state", 32'(state), 32'h002);
    tick(); chk("both_st1", 32'(state), 32'h004);
    wr_go = 1;
    tick(); wr_go = 0;
    chk("wr_ignored", 32'(state), 32'h008);
    mem_ack = 1; mem_rdata = 16'hDEAD;
    tick(); mem_ack = 0;
    chk("early_ack_state", 32'(state), 32'h010);
    chk("early_ack_rd_data", 32'(rd_data), 32'hBEEF);
    tick(); chk("still_wait", 32'(state), 32'h010);
    chk("both_addr", 32'(mem_addr), 32'h11);
    mem_ack = 1; mem_rdata = 16'hC0DE; rd_q.push_back(16'hC0DE);
    tick(); mem_ack = 0;
    chk("both_done_state", 32'(state), 32'h020);
    sb_read("both_done_data");
    clr = 1;
    tick(); clr = 0;
    chk("done_clr_state", 32'(state), 32'h001);

    // Timeout into ERROR.
    addr_in = 8'h77; rd_go = 1;
    tick(); rd_go = 0;
    tick(); tick(); tick();
    chk("to_wait1", 32'(state), 32'h010);
    repeat (7) tick();
    chk("to_wait8", 32'(state), 32'h010);
    tick();
    chk("to_err_state", 32'(state), 32'h000);
    chk("to_err_flag", 32'(err), 32'h1);
    chk("to_err_req", 32'(mem_req), 32'h0);
    chk("to_err_busy", 32'(busy), 32'h0);
    mem_ack = 1; mem_rdata = 16'h5555; rd_go = 1;
    tick(); mem_ack = 0; rd_go = 0;
    chk("err_stray_state", 32'(state), 32'h000);
    chk("err_rd_data", 32'(rd_data), 32'hC0DE);
    clr = 1;
    tick(); clr = 0;
    chk("err_clr_state", 32'(state), 32'h001);
    chk("err_clr_flag", 32'(err), 32'h0);

    // Ack on the last allowed WAIT cycle beats the timeout.
    addr_in = 8'h42; rd_go = 1;
    tick(); rd_go = 0;
    tick(); tick(); tick();
    repeat (7) tick();
    chk("race_wait8", 32'(state), 32'h010);
    mem_ack = 1; mem_rdata = 16'hA5A5; rd_q.push_back(16'hA5A5);
    tick(); mem_ack = 0;
    chk("race_state", 32'(state), 32'h020);
    chk("race_err", 32'(err), 32'h0);
    sb_read("race_data");
    clr = 1;
    tick(); clr = 0;

    // STEP_CYCLES=3 dwell.
    addr_in3 = 8'h99; rd_go3 = 1;
    tick(); rd_go3 = 0;
    for (int k = 1; k <= 10; k++) begin
      exp3 = (k <= 3) ? 12'h002 : (k <= 6) ? 12'h004 : (k <= 9) ? 12'h008 : 12'h010;
      chk($sformatf("step3_c%0d", k), 32'(state3), 32'(exp3));
      if (k < 10) tick();
    end
    chk("step3_req", 32'(mem_req3), 32'h1);
    chk("step3_addr", 32'(mem_addr3), 32'h99);
    mem_ack3 = 1; mem_rdata3 = 16'h0F0F;
    tick(); mem_ack3 = 0;
    chk("step3_done", 32'(state3), 32'h020);
    chk("step3_data", 32'(rd_data3), 32'h0F0F);

    // Asynchronous reset in WRITE_WAIT.
    addr_in = 8'h66; wdata_in = 16'h7777; wr_go = 1;
    wr_q.push_back('{a: 8'h66, d: 16'h7777});
    tick(); wr_go = 0;
    repeat (5) tick();
    chk("arst_pre_state", 32'(state), 32'h800);
    sb_write("arst_pre");
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(state), 32'h001);
    chk("arst_req", 32'(mem_req), 32'h0);
    chk("arst_we", 32'(mem_we), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst_post_state", 32'(state), 32'h001);
    chk("arst_post_rd_data", 32'(rd_data), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
